// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 8-bit ALU between two valid/ready
// requesters. It registers the winning operands onto the ALU, captures the
// result one cycle later and holds it until the owning requester takes it.
module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,

  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,

  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,

  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [7:0] rsp0_data,
  output logic       rsp0_eq,

  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp1_data,
  output logic       rsp1_eq,

  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_ctrl,
  input  logic [7:0] alu_out,
  input  logic       alu_eq,

  output logic       busy
);

  localparam int unsigned DW  = 8;
  localparam int unsigned OPW = 3;
  localparam logic [OPW-1:0] OP_BEQ = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           owner_q, owner_d;
  logic           last_grant_q, last_grant_d;
  logic [DW-1:0]  alu_a_q, alu_a_d;
  logic [DW-1:0]  alu_b_q, alu_b_d;
  logic [OPW-1:0] alu_ctrl_q, alu_ctrl_d;
  logic [DW-1:0]  res_data_q, res_data_d;
  logic           res_eq_q, res_eq_d;

  logic           grant_c;
  logic           grant_vld_c;
  logic           accept_c;
  logic           rsp_done_c;

  // Pick the requester to serve this cycle; a tie goes to req0 in fixed mode,
  // otherwise to whichever requester was not granted last.
  always_comb begin
    grant_vld_c = req0_valid | req1_valid;
    grant_c     = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_c = FIXED_PRIO ? 1'b0 : ~last_grant_q;
    end else if (req1_valid) begin
      grant_c = 1'b1;
    end
  end

  assign accept_c   = (state_q == ST_IDLE) && grant_vld_c;
  assign rsp_done_c = owner_q ? rsp1_ready : rsp0_ready;

  // State register plus all datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= '0;
      res_data_q   <= '0;
      res_eq_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      res_data_q   <= res_data_d;
      res_eq_q     <= res_eq_d;
    end
  end

  // Next-state logic: one accept, one execute cycle, then hold until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c)   state_d = ST_EXEC;
      ST_EXEC:                 state_d = ST_RESP;
      ST_RESP: if (rsp_done_c) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Datapath updates: latch the granted request, then capture the ALU result.
  always_comb begin
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    res_data_d   = res_data_q;
    res_eq_d     = res_eq_q;
    if (accept_c) begin
      owner_d      = grant_c;
      last_grant_d = grant_c;
      alu_a_d      = grant_c ? req1_a  : req0_a;
      alu_b_d      = grant_c ? req1_b  : req0_b;
      alu_ctrl_d   = grant_c ? req1_op : req0_op;
    end
    if (state_q == ST_EXEC) begin
      if (alu_ctrl_q == OP_BEQ) begin
        res_data_d = '0;
        res_eq_d   = alu_eq;
      end else begin
        res_data_d = alu_out;
        res_eq_d   = 1'b0;
      end
    end
  end

  // Output decode from state, owner and the result register.
  always_comb begin
    req0_ready = accept_c && !grant_c;
    req1_ready = accept_c && grant_c;
    rsp0_valid = (state_q == ST_RESP) && !owner_q;
    rsp1_valid = (state_q == ST_RESP) && owner_q;
    rsp0_data  = ((state_q == ST_RESP) && !owner_q) ? res_data_q : '0;
    rsp1_data  = ((state_q == ST_RESP) && owner_q)  ? res_data_q : '0;
    rsp0_eq    = (state_q == ST_RESP) && !owner_q && res_eq_q;
    rsp1_eq    = (state_q == ST_RESP) && owner_q  && res_eq_q;
    busy       = (state_q != ST_IDLE);
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_ctrl = alu_ctrl_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: drives a round-robin and a fixed-priority arbiter with the
// same request streams and compares both against a transaction-level model.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [2:0] req0_op = '0, req1_op = '0;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       rsp0_ready = 1'b0, rsp1_ready = 1'b0;

  // Per-instance outputs: index 0 = round-robin, 1 = fixed priority.
  logic       rdy0 [2];
  logic       rdy1 [2];
  logic       sv0  [2];
  logic       sv1  [2];
  logic       se0  [2];
  logic       se1  [2];
  logic       bsy  [2];
  logic       aeq  [2];
  logic [7:0] sd0  [2];
  logic [7:0] sd1  [2];
  logic [7:0] aa   [2];
  logic [7:0] ab   [2];
  logic [7:0] ao   [2];
  logic [2:0] ac   [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Behavioural ALU; BEQ drives a nonzero junk result the arbiter must drop.
  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a & ~b;
      3'd6: return b - a;
      default: return (a ^ b) | 8'h81;
    endcase
  endfunction

  assign ao[0]  = alu_fn(ac[0], aa[0], ab[0]);
  assign ao[1]  = alu_fn(ac[1], aa[1], ab[1]);
  assign aeq[0] = (aa[0] == ab[0]);
  assign aeq[1] = (aa[1] == ab[1]);

  alu_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(rdy0[0]), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(rdy1[0]), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(sv0[0]), .rsp0_ready(rsp0_ready), .rsp0_data(sd0[0]), .rsp0_eq(se0[0]),
    .rsp1_valid(sv1[0]), .rsp1_ready(rsp1_ready), .rsp1_data(sd1[0]), .rsp1_eq(se1[0]),
    .alu_a(aa[0]), .alu_b(ab[0]), .alu_ctrl(ac[0]), .alu_out(ao[0]), .alu_eq(aeq[0]),
    .busy(bsy[0])
  );

  alu_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(rdy0[1]), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(rdy1[1]), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(sv0[1]), .rsp0_ready(rsp0_ready), .rsp0_data(sd0[1]), .rsp0_eq(se0[1]),
    .rsp1_valid(sv1[1]), .rsp1_ready(rsp1_ready), .rsp1_data(sd1[1]), .rsp1_eq(se1[1]),
    .alu_a(aa[1]), .alu_b(ab[1]), .alu_ctrl(ac[1]), .alu_out(ao[1]), .alu_eq(aeq[1]),
    .busy(bsy[1])
  );

  // Transaction model: one outstanding job per instance, timed by cycle stamps.
  int         cyc;
  bit         pend   [2];
  int         acc    [2];
  bit         own    [2];
  bit         last   [2];
  logic [7:0] res    [2];
  bit         res_eq [2];
  logic [7:0] ea     [2];
  logic [7:0] eb     [2];
  logic [2:0] ec     [2];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected {eq, data} straight from the opcode table, modulo-256 arithmetic.
  function automatic logic [8:0] ref_res(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia = int'(a);
    int ib = int'(b);
    int s;
    case (op)
      3'd0: s = (ia + ib) % 256;
      3'd1: s = (ia - ib + 256) % 256;
      3'd2: s = int'(a & b);
      3'd3: s = int'(a | b);
      3'd4: s = int'(a ^ b);
      3'd5: s = int'(a & ~b);
      3'd6: s = (ib - ia + 256) % 256;
      default: return {(ia == ib), 8'h00};
    endcase
    return {1'b0, 8'(s)};
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; acc[m] = 0; own[m] = 1'b0; last[m] = 1'b1;
      res[m] = '0; res_eq[m] = 1'b0; ea[m] = '0; eb[m] = '0; ec[m] = '0;
    end
  endtask

  // Async reset while inputs are idle; outputs must clear before any edge.
  task automatic do_reset();
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("rst_rsp0_valid[%0d]", m), int'(sv0[m]), 0);
      check($sformatf("rst_rsp1_valid[%0d]", m), int'(sv1[m]), 0);
      check($sformatf("rst_rsp0_data[%0d]", m), int'(sd0[m]), 0);
      check($sformatf("rst_rsp1_data[%0d]", m), int'(sd1[m]), 0);
      check($sformatf("rst_eq[%0d]", m), int'(se0[m] | se1[m]), 0);
      check($sformatf("rst_alu_a[%0d]", m), int'(aa[m]), 0);
      check($sformatf("rst_alu_b[%0d]", m), int'(ab[m]), 0);
      check($sformatf("rst_alu_ctrl[%0d]", m), int'(ac[m]), 0);
      check($sformatf("rst_busy[%0d]", m), int'(bsy[m]), 0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare every output, then advance the model.
  task automatic step(input bit v0, input logic [2:0] o0, input logic [7:0] a0, input logic [7:0] b0,
                      input bit v1, input logic [2:0] o1, input logic [7:0] a1, input logic [7:0] b1,
                      input bit r0, input bit r1);
    bit [1:0] er0, er1;
    bit       vis;
    logic [8:0] rr;
    @(negedge clk);
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    rsp0_ready = r0; rsp1_ready = r1;
    #1;
    for (int m = 0; m < 2; m++) begin
      er0[m] = 1'b0; er1[m] = 1'b0;
      if (!pend[m]) begin
        if (v0 && v1) begin
          if (m == 1 || last[m]) er0[m] = 1'b1; else er1[m] = 1'b1;
        end else if (v0) er0[m] = 1'b1;
        else if (v1) er1[m] = 1'b1;
      end
      vis = pend[m] && (cyc > acc[m]);
      check($sformatf("req0_ready[%0d]", m), int'(rdy0[m]), int'(er0[m]));
      check($sformatf("req1_ready[%0d]", m), int'(rdy1[m]), int'(er1[m]));
      check($sformatf("rsp0_valid[%0d]", m), int'(sv0[m]), int'(vis && !own[m]));
      check($sformatf("rsp1_valid[%0d]", m), int'(sv1[m]), int'(vis && own[m]));
      check($sformatf("busy[%0d]", m), int'(bsy[m]), int'(pend[m]));
      check($sformatf("alu_a[%0d]", m), int'(aa[m]), int'(ea[m]));
      check($sformatf("alu_b[%0d]", m), int'(ab[m]), int'(eb[m]));
      check($sformatf("alu_ctrl[%0d]", m), int'(ac[m]), int'(ec[m]));
      if (vis && !own[m]) begin
        check($sformatf("rsp0_data[%0d]", m), int'(sd0[m]), int'(res[m]));
        check($sformatf("rsp0_eq[%0d]", m), int'(se0[m]), int'(res_eq[m]));
      end
      if (vis && own[m]) begin
        check($sformatf("rsp1_data[%0d]", m), int'(sd1[m]), int'(res[m]));
        check($sformatf("rsp1_eq[%0d]", m), int'(se1[m]), int'(res_eq[m]));
      end
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      vis = pend[m] && (cyc > acc[m]);
      if (vis && (own[m] ? r1 : r0)) pend[m] = 1'b0;
      if (er0[m] || er1[m]) begin
        pend[m] = 1'b1;
        acc[m]  = cyc + 1;
        own[m]  = er1[m];
        last[m] = er1[m];
        ea[m]   = er1[m] ? a1 : a0;
        eb[m]   = er1[m] ? b1 : b0;
        ec[m]   = er1[m] ? o1 : o0;
        rr      = ref_res(ec[m], ea[m], eb[m]);
        res[m]    = rr[7:0];
        res_eq[m] = rr[8];
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    cyc = 0;
    model_reset();
    do_reset();
    idle(2);

    // ADD with wraparound from req0.
    step(1'b1, 3'd0, 8'd200, 8'd100, 1'b0, 3'd0, 8'd0, 8'd0, 1'b1, 1'b1);
    step(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b1, 1'b1);
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("add_wrap_data[%0d]", m), int'(sd0[m]), 44);
      check($sformatf("add_wrap_valid[%0d]", m), int'(sv0[m]), 1);
    end
    idle(3);

    // BEQ from req1, equal then unequal operands.
    step(1'b0, 3'd0, 8'd0, 8'd0, 1'b1, 3'd7, 8'h5A, 8'h5A, 1'b1, 1'b1);
    step(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b1, 1'b1);
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("beq_eq_hit[%0d]", m), int'(se1[m]), 1);
      check($sformatf("beq_data[%0d]", m), int'(sd1[m]), 0);
    end
    idle(2);
    step(1'b0, 3'd0, 8'd0, 8'd0, 1'b1, 3'd7, 8'h5A, 8'h5B, 1'b1, 1'b1);
    step(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b1, 1'b1);
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("beq_eq_miss[%0d]", m), int'(se1[m]), 0);
      check($sformatf("beq_valid[%0d]", m), int'(sv1[m]), 1);
    end
    idle(2);

    // Both requesting continuously: SUB on req0, RSB on req1; then req0 drops.
    for (int i = 0; i < 15; i++) step(1'b1, 3'd1, 8'd9, 8'd4, 1'b1, 3'd6, 8'd9, 8'd4, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++)  step(1'b0, 3'd1, 8'd9, 8'd4, 1'b1, 3'd6, 8'd9, 8'd4, 1'b1, 1'b1);
    idle(3);

    // Back-pressure on req0's response while req1 waits.
    step(1'b1, 3'd3, 8'h0F, 8'hF0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b0, 3'd0, 8'd0, 8'd0, 1'b1, 3'd2, 8'h3C, 8'h0F, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)  step(1'b0, 3'd0, 8'd0, 8'd0, 1'b1, 3'd2, 8'h3C, 8'h0F, 1'b1, 1'b1);
    idle(3);

    // Randomized traffic with random response back-pressure.
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end
    idle(3);

    // Reset while a response is being held.
    step(1'b1, 3'd0, 8'd1, 8'd2, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    do_reset();
    idle(4);
    for (int i = 0; i < 6; i++) step(1'b1, 3'd4, 8'hAA, 8'h55, 1'b1, 3'd5, 8'hFF, 8'h0F, 1'b1, 1'b1);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational 8-bit ALU between two requesters (req0 = core datapath, req1 = auxiliary/debug port) using valid/ready handshakes. The block registers the winning request's operands and opcode onto the ALU inputs, captures the ALU result one cycle later, and holds it until the owning requester accepts it. It sits between the requesters and the ALU instance and is the only driver of the ALU inputs.

## Interface
- FIXED_PRIO, 0, arbitration mode: 0 = round-robin, 1 = req0 always wins a tie.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle when high together with valid.
- req0_op / req1_op  in  3  ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 EOR, 101 BIC, 110 RSB, 111 BEQ.
- req0_a, req0_b / req1_a, req1_b  in  8  operands.
- rsp0_valid / rsp1_valid  out  1  result available for that requester.
- rsp0_ready / rsp1_ready  in  1  requester takes the result.
- rsp0_data / rsp1_data  out  8  result value.
- rsp0_eq / rsp1_eq  out  1  equality flag (BEQ only).
- alu_a, alu_b  out  8  registered ALU operands.
- alu_ctrl  out  3  registered ALU opcode.
- alu_out  in  8  ALU result.
- alu_eq  in  1  ALU equality output.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset -> IDLE.
- Grant (combinational, IDLE only): only one valid -> that one; both valid -> FIXED_PRIO=1: req0; FIXED_PRIO=0: the requester not granted last (last_grant flop).
- reqN_ready = (state==IDLE) && grant==N. Never both high. Low in EXEC and RESP.
- IDLE, accept (valid&&ready): latch op/a/b into alu_ctrl/alu_a/alu_b, store owner, update last_grant, -> EXEC. No accept: stay.
- EXEC (exactly one cycle): at clock edge capture result register: op!=111 -> data=alu_out, eq=0; op==111 -> data=8'h00, eq=alu_eq. -> RESP.
- RESP: rsp<owner>_valid=1, other rsp_valid=0; rsp_data/rsp_eq driven from result register to both requesters (qualified by valid). On rsp<owner>_ready -> IDLE. rsp_ready low -> hold indefinitely, all req_ready stay low.
- alu_a/alu_b/alu_ctrl hold last accepted values until next accept (not cleared in IDLE).
- Arithmetic done by the ALU, modulo 256, no carry/overflow reported.
- Request need not be held stable before acceptance; grant re-evaluated every IDLE cycle. A valid dropped before acceptance is simply ignored.
- rsp_ready from the non-owner is ignored.

## Timing
- Reset (async assert, sync release): state=IDLE, req*_ready reflect IDLE grant from first cycle after release, rsp*_valid=0, rsp*_data=0, rsp*_eq=0, alu_a=alu_b=0, alu_ctrl=000, busy=0, last_grant=1 (req0 wins first tie).
- Reset mid-operation: in-flight op discarded, no response issued.
- Accept at edge N; EXEC during N..N+1; result captured at edge N+1; rsp_valid high from after edge N+1.
- rsp_ready high immediately -> response completes at edge N+2, IDLE after N+2, next accept earliest edge N+3. Max throughput one op per 3 cycles.
- busy rises after accept edge, falls after response edge.

## Test plan
- Reset: assert rst_n=0 mid-RESP -> all outputs to reset values asynchronously, no rsp_valid after release.
- Single req0 ADD a=200 b=100, rsp0_ready=1 -> rsp0_data=44 (wrap), rsp0_eq=0, rsp0_valid exactly one cycle, 3-cycle turnaround.
- BEQ from req1 a=b=8'h5A -> rsp1_eq=1, rsp1_data=0; repeat with b=8'h5B -> rsp1_eq=0.
- Both valid continuously, FIXED_PRIO=0, ops SUB(9,4) on req0 and RSB(9,4) on req1 -> grants alternate req0,req1,req0..., results 5 and 251.
- FIXED_PRIO=1, both valid -> req0 served every time, req1 starved; drop req0_valid -> req1 served next IDLE.
- Back-pressure: rsp0_ready low 10 cycles with req1_valid high -> rsp0_valid/data stable, req1_ready low throughout; raise rsp0_ready -> req1 accepted on the cycle after return to IDLE.
